alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle RV32M MUL unit: low XLEN bits of a_in*b_in.
- Computes by shift-add using the processor's existing combinational ALU through an external port set.
- Holds no adder or shifter of its own: each cycle it issues exactly one ALU operation (ADD, SLL or SRL) and captures ALURes.
- Sits beside the ALU; the core muxes A/B/ALUOp from this block while busy=1.

Parameters:
- XLEN, 32, operand/result width.
- OP_ADD, 4'b0000, ALUOp code for add.
- OP_SLL, 4'b0001, ALUOp code for logical shift left.
- OP_SRL, 4'b0101, ALUOp code for logical shift right.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  XLEN  multiplicand, sampled with start.
- b_in  in  XLEN  multiplier, sampled with start.
- busy  out  1  high in ADD/SHL/SHR states.
- done  out  1  one-cycle pulse in DONE state.
- result  out  XLEN  product low bits; valid from DONE until next accepted start.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_op  out  4  ALU operation code.
- alu_res  in  XLEN  ALU result, combinational from alu_a/alu_b/alu_op in the same cycle.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, alu_a=0, alu_b=0, alu_op=OP_ADD.
- Internal registers (acc, mcand, mplier, 6-bit cnt) clear on reset.
- Reset asserted mid-operation aborts immediately, with no done pulse.
- All ALU outputs are combinational from state and registers.
- IDLE:
  - Drives alu_a=0, alu_b=0, alu_op=OP_ADD.
  - On start=1: mcand<=a_in, mplier<=b_in, acc<=0, cnt<=0.
  - Next state is ADD if b_in[0]=1, else SHL (early-exit variant: DONE if b_in==0).
- ADD: alu_a=acc, alu_b=mcand, alu_op=OP_ADD; acc<=alu_res; next state SHL.
- SHL: alu_a=mcand, alu_b=1, alu_op=OP_SLL; mcand<=alu_res; next state SHR.
- SHR: alu_a=mplier, alu_b=1, alu_op=OP_SRL; mplier<=alu_res; cnt<=cnt+1.
  - Next state DONE if cnt==XLEN-1.
  - Otherwise ADD if alu_res[0]=1, else SHL.
- DONE: busy=0, done=1, result<=acc; next state IDLE. result then holds until the next accepted start.
- Arithmetic: all wrap modulo 2^XLEN; signedness is irrelevant for the low half.
- start outside IDLE (busy or DONE) is ignored, with no queuing. start in the IDLE cycle right after DONE is accepted.
- Latency: start sampled at edge E. done is high during the cycle ending at edge E+N, with N = 2*iters + popcount(b_in) + 1.
  - Without early exit, iters = XLEN.
- Exactly one ALU op per busy cycle; the ALU is never left at an undefined op code.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined:
  - IDLE with start and b_in==0 goes directly to DONE (N=1, result 0).
  - SHR also exits to DONE when alu_res==0.
  - iters = index of highest set bit of b_in + 1.
- Undefined:
  - Always XLEN iterations.
  - Fixed-cost latency of 2*XLEN + popcount(b_in) + 1.
- Result values are identical in both builds.

Test Plan:
- a=6, b=7, start 1 cycle, with a behavioural ALU model attached:
  - result=42.
  - N=10 with ALU_MUL_EARLY_EXIT_EN, N=68 without.
  - busy high exactly N-1 cycles.
  - ALU op sequence begins ADD,SLL,SRL,ADD,SLL,SRL.
- a=0xFFFFFFFD (-3), b=5:
  - result=0xFFFFFFF1.
  - N=9 early-exit, N=67 without.
  - Cycle 2 drives alu_op=OP_SLL, alu_b=1.
- a=0xFFFFFFFF, b=0xFFFFFFFF: result=0x00000001, N=97 in both builds.
- a=123, b=0:
  - result=0.
  - N=1 early-exit (busy never high), N=65 without (no ADD cycles).
- a=9, b=3 started, then start pulsed again with a=2, b=2 while busy: second start ignored, result=27, then exactly one done pulse.
- a=9, b=3 started, rst pulsed in cycle 3:
  - Next cycle busy=0, done=0, result=0, alu_op=OP_ADD.
  - No done pulse follows.
  - A new start (a=4, b=5) then yields result=20.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle RV32M MUL (low XLEN bits of a_in*b_in) that
// borrows the core's combinational ALU instead of owning an adder or shifter.
// Each busy cycle issues exactly one ALU op (ADD, SLL or SRL) and captures
// alu_res. The core muxes alu_a/alu_b/alu_op into its ALU while busy=1.
//
// Optional build macro: ALU_MUL_EARLY_EXIT_EN
//   undefined : always XLEN iterations, latency 2*XLEN + popcount(b) + 1
//   defined   : stops once the remaining multiplier is zero, b==0 finishes in 1
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start, a_in, b_in request and operands, sampled only in IDLE
//   busy, done       busy in ADD/SHL/SHR, done is a one-cycle pulse in DONE
//   result           product low bits, updated on leaving DONE
//   alu_a, alu_b, alu_op, alu_res  borrowed ALU operands/opcode and result

module alu_mul_sequencer #(
  parameter int          XLEN   = 32,
  parameter logic [3:0]  OP_ADD = 4'b0000,
  parameter logic [3:0]  OP_SLL = 4'b0001,
  parameter logic [3:0]  OP_SRL = 4'b0101
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_res
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(XLEN - 1);

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [5:0]      cnt;

  // State, datapath registers and the registered busy/done flags all move
  // together so the flags always describe the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc    <= '0;
            cnt    <= '0;
`ifdef ALU_MUL_EARLY_EXIT_EN
            if (b_in == '0) begin
              // Nothing to add: acc is already the answer.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= b_in[0] ? S_ADD : S_SHL;
              busy  <= 1'b1;
            end
`else
            state <= b_in[0] ? S_ADD : S_SHL;
            busy  <= 1'b1;
`endif
          end
        end

        S_ADD: begin
          acc   <= alu_res;
          state <= S_SHL;
        end

        S_SHL: begin
          mcand <= alu_res;
          state <= S_SHR;
        end

        S_SHR: begin
          mplier <= alu_res;
          cnt    <= cnt + 6'd1;
          // alu_res is the multiplier already shifted, so its bit 0 decides
          // whether the next iteration needs an ADD.
          if (cnt == LAST_CNT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef ALU_MUL_EARLY_EXIT_EN
          end else if (alu_res == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end else begin
            state <= alu_res[0] ? S_ADD : S_SHL;
          end
        end

        S_DONE: begin
          result <= acc;
          done   <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Borrowed-ALU drive: idle/done cycles present a harmless 0+0 ADD so the
  // shared ALU never sees an undefined opcode.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    case (state)
      S_ADD: begin
        alu_a  = acc;
        alu_b  = mcand;
        alu_op = OP_ADD;
      end
      S_SHL: begin
        alu_a  = mcand;
        alu_b  = XLEN'(1);
        alu_op = OP_SLL;
      end
      S_SHR: begin
        alu_a  = mplier;
        alu_b  = XLEN'(1);
        alu_op = OP_SRL;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU attached.
// Expected products and latencies are queued at start and popped on done.
module tb_alu_mul_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0101;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_res_q[$];
  int          exp_n_q[$];
  logic [3:0]  op_log[$];
  logic [31:0] b_log[$];
  int          busy_cycles;
  int          n_obs;

  always #5 clk = ~clk;

  alu_mul_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_res (alu_res)
  );

  // Behavioural stand-in for the core ALU.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SLL:  alu_res = alu_a << alu_b[4:0];
      OP_SRL:  alu_res = alu_a >> alu_b[4:0];
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int calc_n(input logic [31:0] b);
    int iters;
`ifdef ALU_MUL_EARLY_EXIT_EN
    iters = 0;
    for (int i = 0; i < 32; i++) if (b[i]) iters = i + 1;
    if (b == 32'd0) return 1;
`else
    iters = 32;
`endif
    return 2 * iters + $countones(b) + 1;
  endfunction

  function automatic int count_adds();
    int c = 0;
    foreach (op_log[i]) if (op_log[i] == OP_ADD) c++;
    return c;
  endfunction

  // Called at #1 after an edge with the DUT in IDLE; returns #1 after edge E.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    exp_res_q.push_back(a * b);
    exp_n_q.push_back(calc_n(b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Samples each cycle after the start edge until done; optionally pulses a
  // second start (a=2,b=2) at sample index inject_k.
  task automatic collect(input string tag, input int inject_k);
    int          k;
    bit          got;
    int          n_exp;
    logic [31:0] r_exp;
    k = 0; got = 0; busy_cycles = 0; n_obs = 0;
    op_log.delete(); b_log.delete();
    while (!got && k < 400) begin
      if (k == inject_k) begin
        a_in = 32'd2; b_in = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        busy_cycles++;
        op_log.push_back(alu_op);
        b_log.push_back(alu_b);
      end
      if (done) begin
        got   = 1'b1;
        n_obs = k + 1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    r_exp = exp_res_q.pop_front();
    n_exp = exp_n_q.pop_front();
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
    chk({tag, ".latency"}, n_obs, n_exp);
    chk({tag, ".busy_cycles"}, busy_cycles, n_exp - 1);
    @(posedge clk); #1;
    chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, ".result"}, result, r_exp);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int extra;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.alu_a", alu_a, 32'd0);
    chk("reset.alu_b", alu_b, 32'd0);
    chk("reset.alu_op", 32'(alu_op), 32'(OP_ADD));

    // 6*7: op sequence ADD,SLL,SRL,ADD,SLL,SRL
    launch(32'd6, 32'd7);
    collect("mul6x7", -1);
    chk("mul6x7.op0", 32'(op_log[0]), 32'(OP_ADD));
    chk("mul6x7.op1", 32'(op_log[1]), 32'(OP_SLL));
    chk("mul6x7.op2", 32'(op_log[2]), 32'(OP_SRL));
    chk("mul6x7.op3", 32'(op_log[3]), 32'(OP_ADD));
    chk("mul6x7.op4", 32'(op_log[4]), 32'(OP_SLL));
    chk("mul6x7.op5", 32'(op_log[5]), 32'(OP_SRL));
    chk("mul6x7.adds", count_adds(), 32'd3);

    // -3*5, started straight from the IDLE cycle after the previous DONE
    launch(32'hFFFF_FFFD, 32'd5);
    collect("mulm3x5", -1);
    chk("mulm3x5.cyc2_op", 32'(op_log[1]), 32'(OP_SLL));
    chk("mulm3x5.cyc2_b", b_log[1], 32'd1);
    chk("mulm3x5.adds", count_adds(), 32'd2);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("mulmax", -1);
    chk("mulmax.adds", count_adds(), 32'd32);

    launch(32'd123, 32'd0);
    collect("mulzero", -1);
    chk("mulzero.adds", count_adds(), 32'd0);

    // second start while busy must be ignored
    launch(32'd9, 32'd3);
    collect("ignore_start", 2);
    count_dones(100, extra);
    chk("ignore_start.extra_done", extra, 32'd0);
    chk("ignore_start.result_hold", result, 32'd27);

    // reset during the third busy cycle aborts the operation
    launch(32'd9, 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_res_q.pop_front());
    void'(exp_n_q.pop_front());
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.result", result, 32'd0);
    chk("abort.alu_op", 32'(alu_op), 32'(OP_ADD));
    count_dones(100, extra);
    chk("abort.no_done", extra, 32'd0);

    launch(32'd4, 32'd5);
    collect("after_abort", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
